ps2_key_manager: RTL and testbench
==================================

// Module: ps2_key_manager
// PURPOSE
//  PS/2 keyboard front end for the hex-entry display path. It filters the raw PS2_clk line
//  and deserialises 11-bit PS/2 frames. It decodes set-2 make codes into one hex digit or
//  an Enter event. It emits a one-cycle strobe with type flags to the shift register and
//  the display-flush logic.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal clk samples needed to accept a PS2_clk level change
//  TIMEOUT_CYCLES  200000  idle clk cycles mid-frame before the frame is discarded (2 ms at 100 MHz)
// PORTS
//  clk      in   1  system clock (100 MHz); the only clock
//  reset    in   1  synchronous, active-low reset
//  PS2_clk  in   1  raw PS/2 clock, asynchronous
//  PS2_dat  in   1  raw PS/2 data, asynchronous
//  R_O      out  1  one-cycle strobe: an accepted key event is on out/flags
//  out      out  4  hex value of the last accepted digit key (0x0..0xF)
//  flags    out  2  [0]=event is a digit key, [1]=event is Enter; valid only while R_O=1
// BEHAVIOUR
//  - Reset (reset=0 at a clk edge): R_O=0, out=4'h0, flags=2'b00.
//  - Reset also clears the filter (level=1), the bit counter, the shift register and the
//    break/extended prefix latches.
//  - PS2_clk and PS2_dat each pass through a 2-FF synchroniser.
//  - The filtered clk level changes only after FILTER_LEN equal consecutive synced samples.
//  - A filtered 1->0 transition is the sample event. PS2_dat (synced) is captured on that event.
//  - Frame bit order: start(0), d0..d7 LSB first, odd parity, stop(1). A 4-bit counter runs 0..10.
//  - Start bit = 1 means a false start. Counter stays 0 and nothing is recorded.
//  - On bit 10, the frame is valid only if the stop bit = 1 and the XOR of d0..d7 and parity = 1.
//    An invalid frame is dropped silently. Its prefix latches are left unchanged.
//  - Idle timeout: the counter is nonzero and TIMEOUT_CYCLES clks pass with no sample event.
//    The counter returns to 0 and the partial frame is dropped.
//  - Code handling for a valid byte:
//      0xF0: set the break latch; no event.
//      0xE0: set the extended latch; no event.
//      any other byte with the break latch set: clear both latches; no event (key releases ignored).
//      otherwise: decode as a make code, then clear both latches.
//  - Digit map (set 2):
//      0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46
//      A=1C B=32 C=21 D=23 E=24 F=2B
//    The extended latch must be clear for a digit to decode.
//  - Enter: 0x5A, with or without the E0 prefix (main and keypad Enter).
//  - Digit make code: out is loaded with the value, flags=2'b01 and R_O=1 for exactly one cycle.
//  - Enter make code: flags=2'b10 and R_O=1 for one cycle. out is unchanged.
//  - Any other make code produces no strobe.
//  - Latency: R_O is high in the cycle after the clk edge that registers the stop-bit sample event.
//  - flags returns to 00 with R_O. out holds its value between events.
//  - Typematic repeats (repeated make codes without a break) each produce a new strobe.
//  - Simultaneous reset and sample event: reset wins.
//  - Back-to-back frames need no idle gap beyond the PS/2 protocol minimum.
// CONFIGURATION
//  PS2_KEYPAD_EN defined:
//    Numeric keypad make codes also decode as digits, without an E0 prefix:
//    0=70 1=69 2=72 3=7A 4=6B 5=73 6=74 7=6C 8=75 9=7D.
//  PS2_KEYPAD_EN undefined:
//    Keypad codes are treated as unknown (no strobe). Keypad Enter E0 5A is still Enter.
// TESTING
//  - Reset: hold reset=0 for 5 clks -> R_O=0, out=0, flags=00; no strobe while PS2_clk idles high.
//  - Frame 0x1C, parity 0 -> one R_O pulse with out=4'hA, flags=01; then F0 1C -> no further strobe.
//  - Frame 0x5A, then E0 5A -> two R_O pulses with flags=10; out keeps its previous value.
//  - Frame 0x45 with wrong parity (1) -> no strobe. A following valid 0x16 -> out=1, flags=01.
//  - PS2_clk glitch lows of FILTER_LEN-2 cycles mid-frame are ignored.
//    Stopping after 5 bits for more than TIMEOUT_CYCLES, then sending 0x2B -> out=F, single strobe.
//  - With PS2_KEYPAD_EN: 0x7D -> out=9, flags=01. Without it: 0x7D -> no strobe.

Source files
------------

// File: rtl/ps2_key_manager_if.sv
// PS/2 key manager port bundle: raw PS/2 lines in, key-event strobe/value/flags out.
// slave = key manager side, master = keyboard/consumer side.
interface ps2_key_manager_if;
  logic       PS2_clk;
  logic       PS2_dat;
  logic       R_O;
  logic [3:0] out;
  logic [1:0] flags;

  modport slave  (input PS2_clk, PS2_dat, output R_O, out, flags);
  modport master (output PS2_clk, PS2_dat, input R_O, out, flags);
endinterface

// File: rtl/ps2_key_manager.sv
// PS/2 keyboard front end: filters PS2_clk, deserialises frames, decodes set-2 make codes
// into a hex digit or Enter strobe. Define PS2_KEYPAD_EN to also decode numeric keypad digits.
module ps2_key_manager #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_manager_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic       hit;
    logic [3:0] val;
  } digit_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.hit = 1'b1;
    d.val = 4'h0;
    case (code)
      8'h45: d.val = 4'h0;
      8'h16: d.val = 4'h1;
      8'h1E: d.val = 4'h2;
      8'h26: d.val = 4'h3;
      8'h25: d.val = 4'h4;
      8'h2E: d.val = 4'h5;
      8'h36: d.val = 4'h6;
      8'h3D: d.val = 4'h7;
      8'h3E: d.val = 4'h8;
      8'h46: d.val = 4'h9;
      8'h1C: d.val = 4'hA;
      8'h32: d.val = 4'hB;
      8'h21: d.val = 4'hC;
      8'h23: d.val = 4'hD;
      8'h24: d.val = 4'hE;
      8'h2B: d.val = 4'hF;
`ifdef PS2_KEYPAD_EN
      8'h70: d.val = 4'h0;
      8'h69: d.val = 4'h1;
      8'h72: d.val = 4'h2;
      8'h7A: d.val = 4'h3;
      8'h6B: d.val = 4'h4;
      8'h73: d.val = 4'h5;
      8'h74: d.val = 4'h6;
      8'h6C: d.val = 4'h7;
      8'h75: d.val = 4'h8;
      8'h7D: d.val = 4'h9;
`endif
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

  logic          ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
  logic          flt_level_q;
  logic [FW-1:0] flt_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] timer_q;
  logic          brk_q, ext_q;
  logic          r_o_q;
  logic [3:0]    out_q;
  logic [1:0]    flags_q;

  logic   sample_evt_d;
  logic   frame_ok_d;
  digit_t key_d;

  always_comb begin
    sample_evt_d = flt_level_q && !ps2c_sync_q && (flt_cnt_q == FLT_LAST);
    frame_ok_d   = ps2d_sync_q && (^{shift_q, parity_q});
    key_d        = decode_digit(shift_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      flt_level_q <= 1'b1;
      flt_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      r_o_q       <= 1'b0;
      out_q       <= 4'h0;
      flags_q     <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments let each stage see the previous cycle's value,
      // which is what makes the two synchroniser flops a real 2-stage chain.
      ps2c_meta_q <= bus.PS2_clk;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= bus.PS2_dat;
      ps2d_sync_q <= ps2d_meta_q;

      if (ps2c_sync_q == flt_level_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        flt_level_q <= ps2c_sync_q;
        flt_cnt_q   <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end

      r_o_q   <= 1'b0;
      flags_q <= 2'b00;

      if (sample_evt_d) begin
        timer_q <= '0;
        case (bit_cnt_q)
          4'd0:    if (!ps2d_sync_q) bit_cnt_q <= 4'd1;
          4'd9: begin
            parity_q  <= ps2d_sync_q;
            bit_cnt_q <= 4'd10;
          end
          4'd10: begin
            bit_cnt_q <= 4'd0;
            if (frame_ok_d) begin
              if (shift_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else if (shift_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
                // Releases (break prefix seen) are swallowed here without an event.
                if (!brk_q) begin
                  if (shift_q == 8'h5A) begin
                    r_o_q   <= 1'b1;
                    flags_q <= 2'b10;
                  end else if (!ext_q && key_d.hit) begin
                    r_o_q   <= 1'b1;
                    out_q   <= key_d.val;
                    flags_q <= 2'b01;
                  end
                end
              end
            end
          end
          default: begin
            shift_q   <= {ps2d_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        endcase
      end else if (bit_cnt_q != 4'd0) begin
        if (timer_q == TMO_LAST) begin
          bit_cnt_q <= 4'd0;
          timer_q   <= '0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign bus.R_O   = r_o_q;
  assign bus.out   = out_q;
  assign bus.flags = flags_q;

endmodule

// File: tb/tb_ps2_key_manager.sv
// Self-checking bench for ps2_key_manager: scancode-level model with an event queue,
// per-cycle output compare, and literal expectations for the directed scenarios.
module tb_ps2_key_manager;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 30;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_key_manager_if bus();

  ps2_key_manager #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] out;
    logic [1:0] flags;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [3:0] pred_out  = 4'h0;
  logic [3:0] model_out = 4'h0;
  bit   brk = 1'b0, ext = 1'b0;
  bit   mon_en = 1'b0;
  logic prev_ro = 1'b0;
  int   strobe_cnt = 0;
  logic [3:0] last_out   = 4'h0;
  logic [1:0] last_flags = 2'b00;

  logic [7:0] digit_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [7:0] kp_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                8'h75, 8'h7D};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scancode-level model: prefix latches plus table lookup, producing expected events.
  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (b == 8'hF0) brk = 1'b1;
    else if (b == 8'hE0) ext = 1'b1;
    else if (brk) begin
      brk = 1'b0;
      ext = 1'b0;
    end else begin
      if (b == 8'h5A) begin
        e.out = pred_out; e.flags = 2'b10;
        exp_q.push_back(e);
      end else if (!ext) begin
        for (int i = 0; i < 16; i++)
          if (digit_codes[i] == b) begin
            pred_out = 4'(i);
            e.out = pred_out; e.flags = 2'b01;
            exp_q.push_back(e);
          end
`ifdef PS2_KEYPAD_EN
        for (int i = 0; i < 10; i++)
          if (kp_codes[i] == b) begin
            pred_out = 4'(i);
            e.out = pred_out; e.flags = 2'b01;
            exp_q.push_back(e);
          end
`endif
      end
      brk = 1'b0;
      ext = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.R_O === 1'b1) begin
        ev_t e;
        strobe_cnt++;
        last_out   = bus.out;
        last_flags = bus.flags;
        check("strobe_one_cycle", prev_ro, 1'b0);
        check("strobe_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("strobe_out", bus.out, e.out);
          check("strobe_flags", bus.flags, e.flags);
          model_out = e.out;
        end
      end else begin
        check("idle_ro", bus.R_O, 1'b0);
        check("idle_flags", bus.flags, 2'b00);
        check("held_out", bus.out, model_out);
      end
      prev_ro = bus.R_O;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_dat = f[i];
      wait_clks(HALF / 2);
      bus.PS2_clk = 1'b0;
      wait_clks(HALF);
      bus.PS2_clk = 1'b1;
      if (glitch && (i == 4 || i == 7)) begin
        wait_clks(12);
        bus.PS2_clk = 1'b0;
        wait_clks(FILTER_LEN - 2);
        bus.PS2_clk = 1'b1;
        wait_clks(12);
      end else begin
        wait_clks(HALF / 2);
      end
    end
    bus.PS2_dat = 1'b1;
  endtask

  task automatic drain(input string name);
    wait_clks(40);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic key(input logic [7:0] b, input string name);
    model_byte(b);
    send_frame(b, 1'b0, 1'b0, 11, 1'b0);
    drain(name);
  endtask

  int sc0;

  initial begin
    bus.PS2_clk = 1'b1;
    bus.PS2_dat = 1'b1;
    reset = 1'b0;
    wait_clks(5);
    check("reset_ro", bus.R_O, 1'b0);
    check("reset_out", bus.out, 4'h0);
    check("reset_flags", bus.flags, 2'b00);
    reset = 1'b1;
    mon_en = 1'b1;
    wait_clks(60);
    check("idle_no_strobe", strobe_cnt, 0);

    // Digit A, then its release.
    sc0 = strobe_cnt;
    key(8'h1C, "key_1C");
    check("lit_1C_count", strobe_cnt - sc0, 1);
    check("lit_1C_out", last_out, 4'hA);
    check("lit_1C_flags", last_flags, 2'b01);
    sc0 = strobe_cnt;
    key(8'hF0, "brk_F0");
    key(8'h1C, "brk_1C");
    check("lit_release_count", strobe_cnt - sc0, 0);

    // Main and keypad Enter.
    sc0 = strobe_cnt;
    key(8'h5A, "enter_main");
    check("lit_enter_flags", last_flags, 2'b10);
    check("lit_enter_out", last_out, 4'hA);
    key(8'hE0, "enter_e0");
    key(8'h5A, "enter_kp");
    check("lit_enter_count", strobe_cnt - sc0, 2);
    check("lit_kpenter_flags", last_flags, 2'b10);
    check("lit_kpenter_out", last_out, 4'hA);

    // Bad parity, then bad stop bit, then a good frame.
    sc0 = strobe_cnt;
    send_frame(8'h45, 1'b1, 1'b0, 11, 1'b0);
    drain("bad_parity");
    send_frame(8'h46, 1'b0, 1'b1, 11, 1'b0);
    drain("bad_stop");
    check("lit_bad_count", strobe_cnt - sc0, 0);
    key(8'h16, "key_16");
    check("lit_16_out", last_out, 4'h1);
    check("lit_16_flags", last_flags, 2'b01);

    // Short clock glitches mid-frame are filtered out.
    sc0 = strobe_cnt;
    model_byte(8'h24);
    send_frame(8'h24, 1'b0, 1'b0, 11, 1'b1);
    drain("glitch_24");
    check("lit_glitch_count", strobe_cnt - sc0, 1);
    check("lit_glitch_out", last_out, 4'hE);

    // Abandoned frame times out; the next full frame decodes cleanly.
    sc0 = strobe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0);
    wait_clks(TIMEOUT_CYCLES + 200);
    key(8'h2B, "timeout_2B");
    check("lit_timeout_count", strobe_cnt - sc0, 1);
    check("lit_timeout_out", last_out, 4'hF);

    // Typematic repeat.
    sc0 = strobe_cnt;
    key(8'h36, "rep_36a");
    key(8'h36, "rep_36b");
    check("lit_repeat_count", strobe_cnt - sc0, 2);
    check("lit_repeat_out", last_out, 4'h6);

    // Extended digit code, extended release, unknown code: all silent.
    sc0 = strobe_cnt;
    key(8'hE0, "ext_e0");
    key(8'h45, "ext_45");
    key(8'hE0, "extrel_e0");
    key(8'hF0, "extrel_f0");
    key(8'h5A, "extrel_5a");
    key(8'h15, "unknown_15");
    check("lit_silent_count", strobe_cnt - sc0, 0);
    key(8'h3D, "key_3D");
    check("lit_3D_out", last_out, 4'h7);

    // Keypad 9.
    sc0 = strobe_cnt;
    key(8'h7D, "kp_7D");
`ifdef PS2_KEYPAD_EN
    check("lit_kp_count", strobe_cnt - sc0, 1);
    check("lit_kp_out", last_out, 4'h9);
    check("lit_kp_flags", last_flags, 2'b01);
`else
    check("lit_kp_count", strobe_cnt - sc0, 0);
    check("lit_kp_out", bus.out, 4'h7);
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
